mem_port_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port of the 5-stage pipeline.
- Accepts at most one transaction at a time and issues it to memory with a valid/ready handshake.
- Returns the response to the requester that was granted.
- The data port has priority. A starvation guard guarantees forward progress for fetch.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 57 +++++
 rtl/arb_prio_sel.sv | 36 +++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 532 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and default widths for the memory port arbiter
package mem_arb_pkg;

   localparam int DEF_ADDR_W       = 32;
   localparam int DEF_DATA_W       = 32;
   localparam int DEF_STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arbState_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   // Width of a counter that must hold 0..limit inclusive.
   function automatic int cntWidth(input int limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory handshake bundle of the port arbiter
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   localparam int STRB_W = DATA_W / 8;

   logic              i_req_valid;
   logic [ADDR_W-1:0] i_req_addr;
   logic              i_req_ready;
   logic              i_resp_valid;
   logic [DATA_W-1:0] i_resp_data;

   logic              d_req_valid;
   logic              d_req_we;
   logic [ADDR_W-1:0] d_req_addr;
   logic [DATA_W-1:0] d_req_wdata;
   logic [STRB_W-1:0] d_req_wstrb;
   logic              d_req_ready;
   logic              d_resp_valid;
   logic [DATA_W-1:0] d_resp_data;

   logic              m_req_valid;
   logic              m_req_ready;
   logic              m_req_we;
   logic [ADDR_W-1:0] m_req_addr;
   logic [DATA_W-1:0] m_req_wdata;
   logic [STRB_W-1:0] m_req_wstrb;
   logic              m_resp_valid;
   logic [DATA_W-1:0] m_resp_data;

   logic              busy;

   // The arbiter itself
   modport slave (
      input  i_req_valid, i_req_addr,
      output i_req_ready, i_resp_valid, i_resp_data,
      input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
      output d_req_ready, d_resp_valid, d_resp_data,
      output m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_wstrb,
      input  m_req_ready, m_resp_valid, m_resp_data,
      output busy
   );

   // Requesters and memory seen as one environment
   modport master (
      output i_req_valid, i_req_addr,
      input  i_req_ready, i_resp_valid, i_resp_data,
      output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
      input  d_req_ready, d_resp_valid, d_resp_data,
      input  m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_wstrb,
      output m_req_ready, m_resp_valid, m_resp_data,
      input  busy
   );

endinterface

// File: rtl/arb_prio_sel.sv
// rtl/arb_prio_sel.sv - data-priority winner select with a saturating fetch starvation guard
module arb_prio_sel import mem_arb_pkg::*; #(
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic clk,
   input  logic rst,
   input  logic arbEn,
   input  logic iValid,
   input  logic dValid,
   output logic grant_i,
   output logic grant_d
);

   localparam int CW = cntWidth(STARVE_LIMIT);

   logic [CW-1:0] starve_cnt;
   logic          forceI;

   always_comb begin
      forceI  = (STARVE_LIMIT != 0) && (starve_cnt == CW'(STARVE_LIMIT));
      grant_d = arbEn && dValid && !(iValid && forceI);
      grant_i = arbEn && iValid && !grant_d;
   end

   // Only grants that actually beat a waiting fetch count toward the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant_i) begin
         starve_cnt <= '0;
      end else if (grant_d && iValid && (starve_cnt != CW'(STARVE_LIMIT))) begin
         starve_cnt <= starve_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store, one transaction at a time
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter import mem_arb_pkg::*; #(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input logic clk,
   input logic rst,
   mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0] perf_i_grants,
   output logic [31:0] perf_d_grants,
   output logic [31:0] perf_contention
`endif
);

   localparam int STRB_W = DATA_W / 8;

   arbState_t         state;
   arbState_t         stateNext;
   owner_t            owner;
   logic              grant_i;
   logic              grant_d;

   logic              mReqValid;
   logic              mReqWe;
   logic [ADDR_W-1:0] mReqAddr;
   logic [DATA_W-1:0] mReqWdata;
   logic [STRB_W-1:0] mReqWstrb;
   logic              iRespValid;
   logic [DATA_W-1:0] iRespData;
   logic              dRespValid;
   logic [DATA_W-1:0] dRespData;
   logic              busyQ;

   arb_prio_sel #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_sel (
      .clk    (clk),
      .rst    (rst),
      .arbEn  (state == ST_IDLE),
      .iValid (bus.i_req_valid),
      .dValid (bus.d_req_valid),
      .grant_i(grant_i),
      .grant_d(grant_d)
   );

   always_comb begin
      stateNext = state;
      case (state)
         ST_IDLE:  if (grant_i || grant_d) stateNext = ST_ISSUE;
         ST_ISSUE: if (bus.m_req_ready)    stateNext = ST_WAIT;
         ST_WAIT:  if (bus.m_resp_valid)   stateNext = ST_RESP;
         ST_RESP:  stateNext = ST_IDLE;
         default:  stateNext = ST_IDLE;
      endcase
   end

   // Status outputs are decoded from the next state so they flop alongside it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         owner      <= OWN_I;
         mReqValid  <= 1'b0;
         mReqWe     <= 1'b0;
         mReqAddr   <= '0;
         mReqWdata  <= '0;
         mReqWstrb  <= '0;
         iRespValid <= 1'b0;
         iRespData  <= '0;
         dRespValid <= 1'b0;
         dRespData  <= '0;
         busyQ      <= 1'b0;
      end else begin
         state      <= stateNext;
         mReqValid  <= (stateNext == ST_ISSUE);
         busyQ      <= (stateNext != ST_IDLE);
         iRespValid <= (stateNext == ST_RESP) && (owner == OWN_I);
         dRespValid <= (stateNext == ST_RESP) && (owner == OWN_D);

         if (grant_d) begin
            owner     <= OWN_D;
            mReqWe    <= bus.d_req_we;
            mReqAddr  <= bus.d_req_addr;
            mReqWdata <= bus.d_req_wdata;
            mReqWstrb <= bus.d_req_wstrb;
         end else if (grant_i) begin
            owner     <= OWN_I;
            mReqWe    <= 1'b0;
            mReqAddr  <= bus.i_req_addr;
            mReqWdata <= '0;
            mReqWstrb <= '0;
         end

         // Store acks carry whatever the memory drives; the data port sees zero.
         if ((state == ST_WAIT) && bus.m_resp_valid) begin
            if (owner == OWN_D) begin
               dRespData <= mReqWe ? '0 : bus.m_resp_data;
            end else begin
               iRespData <= bus.m_resp_data;
            end
         end
      end
   end

   assign bus.i_req_ready  = grant_i;
   assign bus.d_req_ready  = grant_d;
   assign bus.m_req_valid  = mReqValid;
   assign bus.m_req_we     = mReqWe;
   assign bus.m_req_addr   = mReqAddr;
   assign bus.m_req_wdata  = mReqWdata;
   assign bus.m_req_wstrb  = mReqWstrb;
   assign bus.i_resp_valid = iRespValid;
   assign bus.i_resp_data  = iRespData;
   assign bus.d_resp_valid = dRespValid;
   assign bus.d_resp_data  = dRespData;
   assign bus.busy         = busyQ;

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_i_grants   <= '0;
         perf_d_grants   <= '0;
         perf_contention <= '0;
      end else begin
         if (grant_i) perf_i_grants <= perf_i_grants + 32'd1;
         if (grant_d) perf_d_grants <= perf_d_grants + 32'd1;
         if ((state == ST_IDLE) && bus.i_req_valid && bus.d_req_valid) begin
            perf_contention <= perf_contention + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for the memory port arbiter
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_i_grants, perf_d_grants, perf_contention;
   logic [31:0] perf0_i_grants, perf0_d_grants, perf0_contention;
`endif

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_i_grants  (perf_i_grants),
      .perf_d_grants  (perf_d_grants),
      .perf_contention(perf_contention)
`endif
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(0)) dut0 (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus0)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_i_grants  (perf0_i_grants),
      .perf_d_grants  (perf0_d_grants),
      .perf_contention(perf0_contention)
`endif
   );

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int stallCycles = 0;
   int respDelay = 0;
   int iRespCnt = 0;
   int dRespCnt = 0;
   logic [31:0] iExpQ[$];
   logic [31:0] dExpQ[$];

   function automatic logic [31:0] memData(input logic [31:0] a);
      return (a == 32'h100) ? 32'h0050_0093 : ((a ^ 32'h1357_0000) + 32'h11);
   endfunction

   initial forever begin
      @(posedge clk);
      cycle++;
   end

   // Memory model: ready after stallCycles, response respDelay+1 cycles after acceptance.
   initial begin
      int stallCnt;
      int countdown;
      logic [31:0] pendData;
      stallCnt = 0;
      countdown = 0;
      pendData = '0;
      bus.m_req_ready = 1'b0;
      bus.m_resp_valid = 1'b0;
      bus.m_resp_data = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.m_resp_valid = 1'b0;
         if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
               bus.m_resp_valid = 1'b1;
               bus.m_resp_data = pendData;
            end
         end
         if (bus.m_req_valid) begin
            bus.m_req_ready = (stallCnt >= stallCycles);
            stallCnt++;
         end else begin
            bus.m_req_ready = 1'b0;
            stallCnt = 0;
         end
         @(negedge clk);
         if (bus.m_req_valid && bus.m_req_ready && !rst) begin
            countdown = respDelay + 1;
            pendData = bus.m_req_we ? 32'hFFFF_FFFF : memData(bus.m_req_addr);
            stallCnt = 0;
         end
      end
   end

   // Strict-priority instance: both requesters always valid, zero-latency memory.
   initial begin
      logic acc;
      acc = 1'b0;
      bus0.i_req_valid = 1'b1;
      bus0.i_req_addr = 32'h40;
      bus0.d_req_valid = 1'b1;
      bus0.d_req_we = 1'b0;
      bus0.d_req_addr = 32'h80;
      bus0.d_req_wdata = '0;
      bus0.d_req_wstrb = '0;
      bus0.m_req_ready = 1'b1;
      bus0.m_resp_valid = 1'b0;
      bus0.m_resp_data = '0;
      forever begin
         @(posedge clk);
         #1;
         bus0.m_resp_valid = acc;
         bus0.m_resp_data = 32'h0BAD_F00D;
         @(negedge clk);
         acc = bus0.m_req_valid && bus0.m_req_ready;
      end
   end

   // Response scoreboard
   initial forever begin
      logic [31:0] exp;
      @(negedge clk);
      if (bus.i_resp_valid === 1'b1) begin
         checks++;
         iRespCnt++;
         if (iExpQ.size() == 0) begin
            errors++;
            $display("FAIL i_resp_unexpected: got valid data %h, required no response", bus.i_resp_data);
         end else begin
            exp = iExpQ.pop_front();
            if (bus.i_resp_data !== exp) begin
               errors++;
               $display("FAIL i_resp_data: got %h, expected %h", bus.i_resp_data, exp);
            end
         end
      end
      if (bus.d_resp_valid === 1'b1) begin
         checks++;
         dRespCnt++;
         if (dExpQ.size() == 0) begin
            errors++;
            $display("FAIL d_resp_unexpected: got valid data %h, required no response", bus.d_resp_data);
         end else begin
            exp = dExpQ.pop_front();
            if (bus.d_resp_data !== exp) begin
               errors++;
               $display("FAIL d_resp_data: got %h, expected %h", bus.d_resp_data, exp);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_ready_i(input int budget, output bit ok, output int gcycle);
      ok = 1'b0;
      gcycle = 0;
      for (int n = 0; n < budget && !ok; n++) begin
         @(negedge clk);
         if (bus.i_req_ready === 1'b1) begin
            ok = 1'b1;
            gcycle = cycle;
         end
      end
   endtask

   task automatic wait_ready_d(input int budget, output bit ok, output int gcycle);
      ok = 1'b0;
      gcycle = 0;
      for (int n = 0; n < budget && !ok; n++) begin
         @(negedge clk);
         if (bus.d_req_ready === 1'b1) begin
            ok = 1'b1;
            gcycle = cycle;
         end
      end
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 40 && (iExpQ.size() != 0 || dExpQ.size() != 0); n++) @(negedge clk);
      checks++;
      if (iExpQ.size() != 0 || dExpQ.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d/%0d responses outstanding, expected 0/0", name, iExpQ.size(), dExpQ.size());
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.m_req_valid, bus.i_resp_valid, bus.d_resp_valid, bus.i_req_ready, bus.d_req_ready} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b, expected 000000",
                  {bus.busy, bus.m_req_valid, bus.i_resp_valid, bus.d_resp_valid, bus.i_req_ready, bus.d_req_ready});
      end
      checks++;
      if ({bus.i_resp_data, bus.d_resp_data, bus.m_req_we, bus.m_req_addr, bus.m_req_wdata, bus.m_req_wstrb} !== 133'b0) begin
         errors++;
         $display("FAIL reset_data: got i=%h d=%h addr=%h wdata=%h, expected all zero",
                  bus.i_resp_data, bus.d_resp_data, bus.m_req_addr, bus.m_req_wdata);
      end
`ifdef ARB_PERF_CNT_EN
      checks++;
      if ({perf_i_grants, perf_d_grants, perf_contention} !== 96'b0) begin
         errors++;
         $display("FAIL reset_perf: got %0d/%0d/%0d, expected 0/0/0", perf_i_grants, perf_d_grants, perf_contention);
      end
`endif
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_single_fetch();
      bit ok;
      int t;
      int dBefore;
      dBefore = dRespCnt;
      @(posedge clk);
      #1;
      bus.i_req_valid = 1'b1;
      bus.i_req_addr = 32'h100;
      iExpQ.push_back(32'h0050_0093);
      wait_ready_i(20, ok, t);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL fetch_grant: got no i_req_ready in 20 cycles, expected a grant");
      end
      @(posedge clk);
      #1 bus.i_req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.m_req_valid, bus.m_req_we, bus.m_req_wstrb, bus.m_req_addr} !== {1'b1, 1'b0, 4'b0000, 32'h100}) begin
         errors++;
         $display("FAIL fetch_issue_T1: got valid=%b we=%b strb=%b addr=%h, expected 1 0 0000 00000100",
                  bus.m_req_valid, bus.m_req_we, bus.m_req_wstrb, bus.m_req_addr);
      end
      @(negedge clk);
      checks++;
      if (bus.m_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL fetch_mvalid_T2: got %b, expected 0", bus.m_req_valid);
      end
      @(negedge clk);
      checks++;
      if ({bus.i_resp_valid, bus.d_resp_valid} !== 2'b10) begin
         errors++;
         $display("FAIL fetch_resp_T3: got i=%b d=%b, expected i=1 d=0", bus.i_resp_valid, bus.d_resp_valid);
      end
      @(negedge clk);
      checks++;
      if ({bus.i_resp_valid, bus.busy, dRespCnt - dBefore} !== {2'b00, 32'd0}) begin
         errors++;
         $display("FAIL fetch_end_T4: got resp=%b busy=%b dresps=%0d, expected 0 0 0",
                  bus.i_resp_valid, bus.busy, dRespCnt - dBefore);
      end
   endtask

   task automatic test_store();
      bit ok;
      int t;
      int validCycles;
      int dBefore;
      validCycles = 0;
      dBefore = dRespCnt;
      stallCycles = 3;
      @(posedge clk);
      #1;
      bus.d_req_valid = 1'b1;
      bus.d_req_we = 1'b1;
      bus.d_req_addr = 32'h200;
      bus.d_req_wdata = 32'hDEAD_BEEF;
      bus.d_req_wstrb = 4'b0011;
      dExpQ.push_back(32'h0);
      wait_ready_d(20, ok, t);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL store_grant: got no d_req_ready in 20 cycles, expected a grant");
      end
      @(posedge clk);
      #1;
      bus.d_req_valid = 1'b0;
      bus.d_req_wdata = 32'h0;
      bus.d_req_wstrb = 4'b0000;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (bus.m_req_valid === 1'b1) begin
            validCycles++;
            checks++;
            if ({bus.m_req_we, bus.m_req_addr, bus.m_req_wdata, bus.m_req_wstrb} !== {1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011}) begin
               errors++;
               $display("FAIL store_fields: got we=%b addr=%h wdata=%h strb=%b, expected 1 00000200 deadbeef 0011",
                        bus.m_req_we, bus.m_req_addr, bus.m_req_wdata, bus.m_req_wstrb);
            end
         end
      end
      checks++;
      if (validCycles != 4) begin
         errors++;
         $display("FAIL store_valid_cycles: got %0d, expected 4", validCycles);
      end
      checks++;
      if (dRespCnt - dBefore != 1) begin
         errors++;
         $display("FAIL store_resp_pulses: got %0d, expected 1", dRespCnt - dBefore);
      end
      stallCycles = 0;
      bus.d_req_we = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit ok;
      int t[3];
      @(posedge clk);
      #1 bus.i_req_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.i_req_addr = 32'(4 * k);
         iExpQ.push_back(memData(32'(4 * k)));
         wait_ready_i(20, ok, t[k]);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL b2b_grant%0d: got no i_req_ready in 20 cycles, expected a grant", k);
         end
         @(posedge clk);
         #1;
      end
      bus.i_req_valid = 1'b0;
      for (int k = 1; k < 3; k++) begin
         checks++;
         if (t[k] - t[k-1] != 4) begin
            errors++;
            $display("FAIL b2b_spacing%0d: got %0d cycles, expected 4", k, t[k] - t[k-1]);
         end
      end
      drain("b2b");
   endtask

   task automatic test_contention();
      bit expI[10];
      bit gotI[10];
      int g;
      int cnt;
      bit gi, gd;
      logic [31:0] iAddr, dAddr, lastD;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (cnt == LIMIT && LIMIT != 0) begin
            expI[i] = 1'b1;
            cnt = 0;
         end else begin
            expI[i] = 1'b0;
            if (cnt < LIMIT) cnt++;
         end
      end
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      iAddr = 32'h1000;
      dAddr = 32'h2000;
      lastD = 32'h0;
      bus.d_req_we = 1'b0;
      bus.i_req_addr = iAddr;
      bus.d_req_addr = dAddr;
      bus.i_req_valid = 1'b1;
      bus.d_req_valid = 1'b1;
      g = 0;
      for (int n = 0; n < 200 && g < 10; n++) begin
         @(negedge clk);
         gi = (bus.i_req_ready === 1'b1);
         gd = (bus.d_req_ready === 1'b1);
         if (gd) begin
            gotI[g] = 1'b0;
            dExpQ.push_back(memData(dAddr));
            lastD = memData(dAddr);
            g++;
         end else if (gi) begin
            gotI[g] = 1'b1;
            iExpQ.push_back(memData(iAddr));
            g++;
         end
         @(posedge clk);
         #1;
         if (gd) dAddr += 32'h4;
         if (gi) iAddr += 32'h4;
         bus.i_req_addr = iAddr;
         bus.d_req_addr = dAddr;
      end
      bus.i_req_valid = 1'b0;
      bus.d_req_valid = 1'b0;
      checks++;
      if (g != 10) begin
         errors++;
         $display("FAIL contention_grants: got %0d grants, expected 10", g);
      end
      for (int i = 0; i < g; i++) begin
         checks++;
         if (gotI[i] !== expI[i]) begin
            errors++;
            $display("FAIL contention_order%0d: got %s, expected %s", i, gotI[i] ? "I" : "D", expI[i] ? "I" : "D");
         end
      end
`ifdef ARB_PERF_CNT_EN
      @(negedge clk);
      checks++;
      if ({perf_d_grants, perf_i_grants, perf_contention} !== {32'd8, 32'd2, 32'd10}) begin
         errors++;
         $display("FAIL perf_counts: got d=%0d i=%0d cont=%0d, expected d=8 i=2 cont=10",
                  perf_d_grants, perf_i_grants, perf_contention);
      end
`endif
      drain("contention");
      @(negedge clk);
      checks++;
      if (bus.d_resp_data !== lastD) begin
         errors++;
         $display("FAIL d_resp_hold: got %h, expected %h", bus.d_resp_data, lastD);
      end
   endtask

   task automatic test_strict_priority();
      int iG, dG;
      iG = 0;
      dG = 0;
      for (int n = 0; n < 200 && dG < 10; n++) begin
         @(negedge clk);
         if (bus0.i_req_ready === 1'b1) iG++;
         if (bus0.d_req_ready === 1'b1) dG++;
      end
      checks++;
      if (dG != 10 || iG != 0) begin
         errors++;
         $display("FAIL strict_prio: got d=%0d i=%0d grants, expected d=10 i=0", dG, iG);
      end
`ifdef ARB_PERF_CNT_EN
      checks++;
      if (perf0_i_grants !== 32'd0 || perf0_contention !== perf0_d_grants) begin
         errors++;
         $display("FAIL strict_perf: got i=%0d cont=%0d d=%0d, expected i=0 and cont equal to d",
                  perf0_i_grants, perf0_contention, perf0_d_grants);
      end
`endif
   endtask

   task automatic test_reset_mid();
      bit ok;
      int t;
      int iBefore, dBefore;
      respDelay = 3;
      @(posedge clk);
      #1;
      bus.i_req_valid = 1'b1;
      bus.i_req_addr = 32'h300;
      iExpQ.push_back(memData(32'h300));
      wait_ready_i(20, ok, t);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rstmid_grant: got no i_req_ready in 20 cycles, expected a grant");
      end
      @(posedge clk);
      #1 bus.i_req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      iExpQ.delete();
      iBefore = iRespCnt;
      dBefore = dRespCnt;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         checks++;
         if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_busy%0d: got %b, expected 0", n, bus.busy);
         end
      end
      checks++;
      if (iRespCnt != iBefore || dRespCnt != dBefore) begin
         errors++;
         $display("FAIL rstmid_no_resp: got %0d/%0d responses, expected 0/0", iRespCnt - iBefore, dRespCnt - dBefore);
      end
      respDelay = 0;
      @(posedge clk);
      #1;
      bus.i_req_valid = 1'b1;
      iExpQ.push_back(memData(32'h300));
      wait_ready_i(20, ok, t);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rstmid_regrant: got no i_req_ready in 20 cycles, expected a grant");
      end
      @(posedge clk);
      #1 bus.i_req_valid = 1'b0;
      drain("rstmid");
   endtask

   initial begin
      bus.i_req_valid = 1'b0;
      bus.i_req_addr = '0;
      bus.d_req_valid = 1'b0;
      bus.d_req_we = 1'b0;
      bus.d_req_addr = '0;
      bus.d_req_wdata = '0;
      bus.d_req_wstrb = '0;
      test_reset();
      test_single_fetch();
      test_store();
      test_back_to_back();
      test_contention();
      test_strict_priority();
      test_reset_mid();
      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
